// File: rtl/iq_issue_ctrl.sv
// iq_issue_ctrl: single-entry issue stage between decode and the ROB /
// reservation stations / register file. Holds one decoded instruction and
// issues it in one cycle once a ROB slot and a reservation station are free.
// Optional feature macro: IQ_ISSUE_STATS_EN (adds stat_issued/stat_stalled).
module iq_issue_ctrl #(
    parameter int ROB_IDX_W = 5,
    parameter int NUM_RS    = 10,
    parameter int RS_SEL_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [4:0]           instr_rd,
    input  logic [4:0]           instr_rs1,
    input  logic [4:0]           instr_rs2,
    input  logic [2:0]           instr_alu_op,
    input  logic                 instr_use_imm,
    input  logic [31:0]          instr_imm,
    input  logic [ROB_IDX_W-1:0] rob_tail,
    input  logic                 rob_full,
    input  logic [NUM_RS-1:0]    rs_busy,
    output logic [4:0]           lookup_regfile_1,
    output logic [4:0]           lookup_regfile_2,
    input  logic [31:0]          rf_src1_value,
    input  logic [31:0]          rf_src2_value,
    input  logic                 rf_src1_busy,
    input  logic                 rf_src2_busy,
    input  logic [ROB_IDX_W-1:0] rf_src1_rob,
    input  logic [ROB_IDX_W-1:0] rf_src2_rob,
    input  logic                 cdb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_rob,
    input  logic [31:0]          cdb_value,
    output logic                 rf_write,
    output logic [4:0]           rf_rd,
    output logic [ROB_IDX_W-1:0] rf_rob_index,
    output logic                 rob_issue,
    output logic [4:0]           rob_dr,
    output logic                 load_RS,
    output logic [RS_SEL_W-1:0]  RS_sel,
    output logic [ROB_IDX_W-1:0] dest_rob,
    output logic [2:0]           alu_ops,
    output logic                 src1_valid,
    output logic                 src2_valid,
    output logic [31:0]          src1_value,
    output logic [31:0]          src2_value,
    output logic [ROB_IDX_W-1:0] src1_rob,
    output logic [ROB_IDX_W-1:0] src2_rob
`ifdef IQ_ISSUE_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stalled
`endif
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  alu_op;
        logic        use_imm;
        logic [31:0] imm;
    } instr_t;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          value;
        logic [ROB_IDX_W-1:0] tag;
    } src_t;

    logic   held_valid_q, held_valid_d;
    instr_t held_q, held_d;
    logic   issue_fire, accept, rs_free, rs_found;
    logic [RS_SEL_W-1:0] rs_idx;
    src_t   s1, s2;

    // Operand resolution: x0, then register file, then same-cycle CDB bypass.
    function automatic src_t resolve(input logic [4:0] rs, input logic [31:0] rf_val,
                                     input logic rf_busy, input logic [ROB_IDX_W-1:0] rf_tag);
        src_t r;
        r = '0;
        if (rs == 5'd0) begin
            r.valid = 1'b1;
        end else if (!rf_busy) begin
            r.valid = 1'b1;
            r.value = rf_val;
        end else if (cdb_valid && (cdb_rob == rf_tag)) begin
            r.valid = 1'b1;
            r.value = cdb_value;
        end else begin
            r.tag = rf_tag;
        end
        return r;
    endfunction

    // Lowest-index free reservation station.
    always_comb begin
        rs_idx   = '0;
        rs_found = 1'b0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (!rs_busy[i] && !rs_found) begin
                rs_idx   = RS_SEL_W'(i);
                rs_found = 1'b1;
            end
        end
    end

    assign rs_free     = |(~rs_busy);
    assign issue_fire  = held_valid_q & ~rob_full & rs_free & ~flush;
    assign instr_ready = ~held_valid_q | issue_fire;
    assign accept      = instr_valid & instr_ready;

    assign lookup_regfile_1 = held_q.rs1;
    assign lookup_regfile_2 = held_q.rs2;

    // Holding register next state: flush wins over accept, accept over drain.
    always_comb begin
        held_valid_d = held_valid_q;
        held_d       = held_q;
        if (flush) begin
            held_valid_d = 1'b0;
        end else if (accept) begin
            held_valid_d = 1'b1;
            held_d       = '{rd: instr_rd, rs1: instr_rs1, rs2: instr_rs2,
                             alu_op: instr_alu_op, use_imm: instr_use_imm, imm: instr_imm};
        end else if (issue_fire) begin
            held_valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_valid_q <= 1'b0;
            held_q       <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            held_q       <= held_d;
        end
    end

    // Issue outputs, all forced to zero unless this cycle issues.
    always_comb begin
        s1 = resolve(held_q.rs1, rf_src1_value, rf_src1_busy, rf_src1_rob);
        s2 = resolve(held_q.rs2, rf_src2_value, rf_src2_busy, rf_src2_rob);
        if (held_q.use_imm) begin
            s2 = '{valid: 1'b1, value: held_q.imm, tag: '0};
        end
        rob_issue    = 1'b0;
        rob_dr       = '0;
        rf_write     = 1'b0;
        rf_rd        = '0;
        rf_rob_index = '0;
        load_RS      = 1'b0;
        RS_sel       = '0;
        dest_rob     = '0;
        alu_ops      = '0;
        src1_valid   = 1'b0;
        src1_value   = '0;
        src1_rob     = '0;
        src2_valid   = 1'b0;
        src2_value   = '0;
        src2_rob     = '0;
        if (issue_fire) begin
            rob_issue    = 1'b1;
            rob_dr       = held_q.rd;
            rf_write     = (held_q.rd != 5'd0);
            rf_rd        = held_q.rd;
            rf_rob_index = rob_tail;
            load_RS      = 1'b1;
            RS_sel       = rs_idx;
            dest_rob     = rob_tail;
            alu_ops      = held_q.alu_op;
            src1_valid   = s1.valid;
            src1_value   = s1.value;
            src1_rob     = s1.tag;
            src2_valid   = s2.valid;
            src2_value   = s2.value;
            src2_rob     = s2.tag;
        end
    end

`ifdef IQ_ISSUE_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d, stat_stalled_q, stat_stalled_d;

    // Saturating issue / stall counters.
    always_comb begin
        stat_issued_d  = stat_issued_q;
        stat_stalled_d = stat_stalled_q;
        if (issue_fire && !(&stat_issued_q)) begin
            stat_issued_d = stat_issued_q + 32'd1;
        end
        if (held_valid_q && !issue_fire && !flush && !(&stat_stalled_q)) begin
            stat_stalled_d = stat_stalled_q + 32'd1;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_issued_q  <= '0;
            stat_stalled_q <= '0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_stalled_q <= stat_stalled_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_stalled = stat_stalled_q;
`endif

endmodule

// File: doc/iq_issue_ctrl.md
# iq_issue_ctrl

Issue-side initiator for the ROB / reservation-station / register-file issue interface. It accepts one decoded instruction per cycle from decode into a single-entry holding register. When a ROB slot and a reservation station are both free, it issues the held instruction in one cycle:
- allocates the ROB tail entry;
- renames `rd` in the register file;
- loads a free reservation station with resolved source operands.

## Interface
Parameters:
- `ROB_IDX_W`, 5: ROB index width (32 entries).
- `NUM_RS`, 10: number of reservation stations.
- `RS_SEL_W`, 4: width of the RS select field.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous squash of the held instruction.
- `instr_valid`, in, 1: decode offers an instruction.
- `instr_ready`, out, 1: holding register can accept.
- `instr_rd`, `instr_rs1`, `instr_rs2`, in, 5 each: register specifiers.
- `instr_alu_op`, in, 3: ALU operation.
- `instr_use_imm`, in, 1: src2 is the immediate.
- `instr_imm`, in, 32: immediate value.
- `rob_tail`, in, `ROB_IDX_W`: index the next allocation receives.
- `rob_full`, in, 1: ROB circular queue full.
- `rs_busy`, in, `NUM_RS`: per-station busy flags.
- `lookup_regfile_1`, `lookup_regfile_2`, out, 5 each: register-file read addresses (combinational).
- `rf_src1_value`, `rf_src2_value`, in, 32 each: register-file read data.
- `rf_src1_busy`, `rf_src2_busy`, in, 1 each: register is renamed.
- `rf_src1_rob`, `rf_src2_rob`, in, `ROB_IDX_W` each: producer tag.
- `cdb_valid`, in, 1: result broadcast strobe.
- `cdb_rob`, in, `ROB_IDX_W`: broadcast tag.
- `cdb_value`, in, 32: broadcast result.
- `rf_write`, out, 1: rename `rf_rd` to `rf_rob_index`.
- `rf_rd`, out, 5: register being renamed.
- `rf_rob_index`, out, `ROB_IDX_W`: new producer tag.
- `rob_issue`, out, 1: allocate ROB entry.
- `rob_dr`, out, 5: destination register.
- `load_RS`, out, 1: load reservation station `RS_sel`.
- `RS_sel`, out, `RS_SEL_W`: selected station.
- `dest_rob`, out, `ROB_IDX_W`: station's destination tag.
- `alu_ops`, out, 3: station ALU operation.
- `src1_valid`, `src2_valid`, out, 1 each: operand value present.
- `src1_value`, `src2_value`, out, 32 each: operand values.
- `src1_rob`, `src2_rob`, out, `ROB_IDX_W` each: tags awaited when not valid.

## Operation
- Holding register: `held_valid` plus all `instr_*` fields.
- `issue_fire = held_valid & ~rob_full & (|~rs_busy) & ~flush`.
- `instr_ready = ~held_valid | issue_fire`. Accept when `instr_valid & instr_ready`.
- On accept the register loads the new instruction. On `issue_fire` without accept, `held_valid` clears. On `flush`, `held_valid` clears and any same-cycle accept is dropped.
- Issue outputs are combinational from the held instruction and are gated by `issue_fire`. When `issue_fire` is low, all strobes are 0 and data outputs are 0.
- ROB allocation: `rob_issue = 1`, `rob_dr = rd`. `dest_rob` and `rf_rob_index` both equal `rob_tail`.
- Rename: `rf_write = issue_fire & (rd != 0)`. x0 is never renamed, but it still allocates a ROB entry.
- RS select: the lowest index `i` with `rs_busy[i] == 0`.
- Source resolution, per operand, first matching rule wins:
  - rs == 0: valid, value 0.
  - Register not busy: valid, register-file value.
  - Busy, and `cdb_valid` with `cdb_rob` equal to the tag: valid, `cdb_value`.
  - Otherwise: not valid, value 0, `srcN_rob` = tag.
- `use_imm` forces src2 valid with value `imm` and `src2_rob` 0.
- `srcN_rob` is 0 whenever the operand is valid.
- Stall: the held instruction stays unchanged while `rob_full` or all stations are busy. Lookups are re-evaluated every cycle.

## Timing
- Reset (`rst` low, asynchronous): `held_valid` = 0, so `instr_ready` = 1 and every issue output is 0. This holds immediately and for as long as `rst` is low.
- Reset mid-stall discards the held instruction with no issue pulse.
- Latency: an instruction accepted at edge N drives its issue strobes during cycle N→N+1. The ROB, register file and RS sample them at edge N+1.
- Back-to-back issue gives 1 instruction per cycle.
- A dependent instruction issued at N+1 observes the rename written at edge N+1, so no internal forwarding is required.
- Each strobe is high for exactly one cycle per issued instruction.

## Configuration
- `IQ_ISSUE_STATS_EN`: when defined, adds two outputs, both cleared by reset and saturating at all-ones:
  - `stat_issued` (32): counts `issue_fire` cycles.
  - `stat_stalled` (32): counts `held_valid & ~issue_fire & ~flush` cycles.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

## Test plan
- Reset, then offer `rd=3, rs1=rs2=0, alu_op=0` with `rob_tail=0` and all RS free.
  - Required one cycle later: `rob_issue=1`, `rob_dr=3`, `rf_write=1`, `rf_rd=3`, `rf_rob_index=0`, `load_RS=1`, `RS_sel=0`, both sources valid with value 0.
- Issue 10 instructions back-to-back, `rd=i`, with `rs_busy` tracking the loads.
  - Required: `RS_sel` = 0..9 on consecutive cycles and `instr_ready` held 1.
  - The 11th instruction stalls, and `instr_ready` drops, until `rs_busy[4]` clears; it then issues with `RS_sel=4`.
- Src1 busy with tag 7 and `cdb_valid`, `cdb_rob=7`, `cdb_value=156` in the issue cycle.
  - Required: `src1_valid=1`, `src1_value=156`.
  - Without the broadcast: `src1_valid=0`, `src1_rob=7`.
- `rob_full=1` for 3 cycles with a held instruction.
  - Required: no strobes and the instruction unchanged.
  - Required: issue on the first cycle after `rob_full` falls.
- `rd=0`, `use_imm=1`, `imm=4`.
  - Required: `rob_issue=1`, `rf_write=0`, `src2_valid=1`, `src2_value=4`.
- Assert `flush` while an instruction is stalled, and separately assert `rst` while one is held.
  - Required in both cases: the instruction is dropped, no issue pulse occurs, and `instr_ready=1` on the following cycle.
